// File: rtl/aes_block_assembler_pkg.sv
// ============================================================================
// Module   : aes_block_assembler_pkg
// Purpose  : Shared types and constants for the AES block assembler.
//            Holds the FSM state encoding and the default word/block geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_block_assembler_pkg;

    localparam int AES_WORD_W   = 32;
    localparam int AES_NB_WORDS = 4;

    typedef enum logic [1:0] {
        AES_ASM_COLLECT = 2'd0,
        AES_ASM_START   = 2'd1,
        AES_ASM_WAIT    = 2'd2,
        AES_ASM_DRAIN   = 2'd3
    } aes_asm_state_t;

endpackage : aes_block_assembler_pkg

`default_nettype wire

// File: rtl/aes_block_assembler.sv
// ============================================================================
// Module   : aes_block_assembler
// Purpose  : Packs NUM_WORDS plaintext words into one cipher block, hands it to
//            the AES core with a start/done handshake, latches the result and
//            serialises it word by word to the ciphertext sink. Loops
//            COLLECT -> START -> WAIT -> DRAIN -> COLLECT.
// Config   : AES_ASM_LOOPBACK_EN - bypass the core; the result is block ^ key_i
//            latched one cycle after START, core_start_o is tied low and
//            core_done_i / core_result_i are ignored.
// Ports    : clk, reset_n (async, active-low), clear (sync, same as reset)
//            key_i                      cipher key (loopback only)
//            pt_valid_i/pt_ready_o/pt_data_i       plaintext word stream
//            core_start_o/core_block_o             block to cipher core
//            core_done_i/core_result_i             result from cipher core
//            ct_valid_o/ct_ready_i/ct_data_o       ciphertext word stream
//            busy_o                     not idle (COLLECT with no words taken)
//            block_done_o               pulse after last ciphertext word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_block_assembler
    import aes_block_assembler_pkg::*;
#(
    parameter int DATA_WIDTH = AES_WORD_W,
    parameter int NUM_WORDS  = AES_NB_WORDS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] key_i,
    input  logic                          pt_valid_i,
    output logic                          pt_ready_o,
    input  logic [DATA_WIDTH-1:0]         pt_data_i,
    output logic                          core_start_o,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] core_block_o,
    input  logic                          core_done_i,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] core_result_i,
    output logic                          ct_valid_o,
    input  logic                          ct_ready_i,
    output logic [DATA_WIDTH-1:0]         ct_data_o,
    output logic                          busy_o,
    output logic                          block_done_o
);

    localparam int BLOCK_W = DATA_WIDTH * NUM_WORDS;
    localparam int CNT_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(NUM_WORDS - 1);

    aes_asm_state_t     r_state;
    aes_asm_state_t     w_state_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   w_word_cnt_next;
    logic [BLOCK_W-1:0] r_block;
    logic [BLOCK_W-1:0] r_result;
    logic [BLOCK_W-1:0] w_result_next;
    logic               w_result_load;
    logic               r_block_done;
    logic               w_block_done_next;
    logic               w_pt_hs;
    logic               w_ct_hs;

    // Handshakes are qualified by the state decode, so a stray ready or
    // valid outside its own phase can never move data.
    assign w_pt_hs = (r_state == AES_ASM_COLLECT) && pt_valid_i;
    assign w_ct_hs = (r_state == AES_ASM_DRAIN)   && ct_ready_i;

`ifdef AES_ASM_LOOPBACK_EN
    logic w_unused_core;
    assign w_unused_core = core_done_i ^ (^core_result_i);
    assign core_start_o  = 1'b0;
`else
    logic w_unused_key;
    assign w_unused_key  = ^key_i;
    assign core_start_o  = (r_state == AES_ASM_START);
`endif

    assign pt_ready_o   = (r_state == AES_ASM_COLLECT);
    assign ct_valid_o   = (r_state == AES_ASM_DRAIN);
    assign ct_data_o    = r_result[r_word_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign core_block_o = r_block;
    assign busy_o       = !((r_state == AES_ASM_COLLECT) && (r_word_cnt == '0));
    assign block_done_o = r_block_done;

    // ------------------------------------------------------------------
    // Next-state / next-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_word_cnt_next   = r_word_cnt;
        w_block_done_next = 1'b0;
        w_result_load     = 1'b0;
        w_result_next     = r_result;

        case (r_state)
            AES_ASM_COLLECT: begin
                if (w_pt_hs) begin
                    if (r_word_cnt == C_LAST_WORD) begin
                        w_word_cnt_next = '0;
                        w_state_next    = AES_ASM_START;
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_W'(1);
                    end
                end
            end

            AES_ASM_START: begin
                w_state_next = AES_ASM_WAIT;
            end

            AES_ASM_WAIT: begin
`ifdef AES_ASM_LOOPBACK_EN
                // Fixed one-cycle "cipher": XOR with the key.
                w_result_load = 1'b1;
                w_result_next = r_block ^ key_i;
                w_state_next  = AES_ASM_DRAIN;
`else
                if (core_done_i) begin
                    w_result_load = 1'b1;
                    w_result_next = core_result_i;
                    w_state_next  = AES_ASM_DRAIN;
                end
`endif
            end

            AES_ASM_DRAIN: begin
                if (w_ct_hs) begin
                    if (r_word_cnt == C_LAST_WORD) begin
                        w_word_cnt_next   = '0;
                        w_block_done_next = 1'b1;
                        w_state_next      = AES_ASM_COLLECT;
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_next    = AES_ASM_COLLECT;
                w_word_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. clear has the same effect as reset,
    // so a clear on the final drain handshake suppresses block_done_o.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= AES_ASM_COLLECT;
            r_word_cnt   <= '0;
            r_block      <= '0;
            r_result     <= '0;
            r_block_done <= 1'b0;
        end else if (clear) begin
            r_state      <= AES_ASM_COLLECT;
            r_word_cnt   <= '0;
            r_block      <= '0;
            r_result     <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word_cnt   <= w_word_cnt_next;
            r_block_done <= w_block_done_next;
            if (w_pt_hs) begin
                // Word 0 lands in the least significant bits.
                r_block[r_word_cnt*DATA_WIDTH +: DATA_WIDTH] <= pt_data_i;
            end
            if (w_result_load) begin
                r_result <= w_result_next;
            end
        end
    end

endmodule : aes_block_assembler

`default_nettype wire

// File: tb/tb_aes_block_assembler.sv
// ============================================================================
// Module   : tb_aes_block_assembler
// Purpose  : Directed self-checking bench for aes_block_assembler. With
//            AES_ASM_LOOPBACK_EN defined it runs the key-XOR loopback case;
//            otherwise it runs the core-handshake cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_block_assembler;

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic [127:0] key;
    logic         pt_valid;
    logic         pt_ready;
    logic [31:0]  pt_data;
    logic         core_start;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;
    logic         ct_valid;
    logic         ct_ready;
    logic [31:0]  ct_data;
    logic         busy;
    logic         block_done;

    int total = 0;
    int bad   = 0;
    int start_pulses = 0;

    aes_block_assembler #(
        .DATA_WIDTH (32),
        .NUM_WORDS  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .key_i         (key),
        .pt_valid_i    (pt_valid),
        .pt_ready_o    (pt_ready),
        .pt_data_i     (pt_data),
        .core_start_o  (core_start),
        .core_block_o  (core_block),
        .core_done_i   (core_done),
        .core_result_i (core_result),
        .ct_valid_o    (ct_valid),
        .ct_ready_i    (ct_ready),
        .ct_data_o     (ct_data),
        .busy_o        (busy),
        .block_done_o  (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_pulses++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        pt_valid = 1'b1;
        pt_data  = d;
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic core_reply(input logic [127:0] r);
        core_done   = 1'b1;
        core_result = r;
        tick();
        core_done   = 1'b0;
    endtask

    task automatic drain_all(input string tag, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            ct_ready = 1'b1;
            check({tag, "_valid"}, 128'(ct_valid), 128'd1);
            check({tag, "_data"},  128'(ct_data), 128'(blk[i*32 +: 32]));
            tick();
        end
        ct_ready = 1'b0;
        check({tag, "_done"}, 128'(block_done), 128'd1);
        check({tag, "_ready_back"}, 128'(pt_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] blk;
        logic [31:0]  exp3 [4];
        int           idx;
        int           s0;

        reset_n     = 1'b0;
        clear       = 1'b0;
        key         = 128'h0;
        pt_valid    = 1'b0;
        pt_data     = 32'h0;
        core_done   = 1'b0;
        core_result = 128'h0;
        ct_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pt_ready",   128'(pt_ready),   128'd1);
        check("rst_core_start", 128'(core_start), 128'd0);
        check("rst_ct_valid",   128'(ct_valid),   128'd0);
        check("rst_busy",       128'(busy),       128'd0);
        check("rst_block_done", 128'(block_done), 128'd0);
        check("rst_core_block", core_block,       128'd0);
        reset_n = 1'b1;
        tick();

`ifdef AES_ASM_LOOPBACK_EN
        // Loopback: zeros XOR all-ones key must come out as all-ones words.
        key = {128{1'b1}};
        s0  = start_pulses;
        for (int i = 0; i < 4; i++) send_word(32'h0);
        check("lb_start_low", 128'(core_start), 128'd0);
        check("lb_busy",      128'(busy),       128'd1);
        tick();                       // WAIT
        check("lb_wait_novalid", 128'(ct_valid), 128'd0);
        tick();                       // DRAIN
        drain_all("lb", {128{1'b1}});
        tick();
        check("lb_done_pulse", 128'(block_done), 128'd0);
        check("lb_no_start", 128'(start_pulses - s0), 128'd0);
`else
        // Test 1: four words back to back.
        s0 = start_pulses;
        send_word(32'h00112233);
        check("t1_busy_mid", 128'(busy), 128'd1);
        send_word(32'h44556677);
        send_word(32'h8899AABB);
        send_word(32'hCCDDEEFF);
        check("t1_start", 128'(core_start), 128'd1);
        check("t1_block", core_block, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        check("t1_ready_low", 128'(pt_ready), 128'd0);
        tick();                       // WAIT
        check("t1_start_off", 128'(core_start), 128'd0);

        // Test 2: core answers after ~10 cycles.
        for (int i = 0; i < 9; i++) begin
            check("t2_wait_novalid", 128'(ct_valid), 128'd0);
            tick();
        end
        core_reply({16{8'h0F}});
        drain_all("t2", {16{8'h0F}});
        check("t2_ct_valid_off", 128'(ct_valid), 128'd0);
        check("t2_busy_off", 128'(busy), 128'd0);
        tick();
        check("t2_done_single", 128'(block_done), 128'd0);
        check("t2_one_start", 128'(start_pulses - s0), 128'd1);

        // Test 3: random back-pressure on the ciphertext side.
        send_word(32'h01010101);
        send_word(32'h02020202);
        send_word(32'h03030303);
        send_word(32'h04040404);
        tick();                       // WAIT
        exp3[0] = 32'hA0A1A2A3;
        exp3[1] = 32'hB0B1B2B3;
        exp3[2] = 32'hC0C1C2C3;
        exp3[3] = 32'hD0D1D2D3;
        core_reply({exp3[3], exp3[2], exp3[1], exp3[0]});
        idx = 0;
        for (int c = 0; c < 200 && idx < 4; c++) begin
            ct_ready = 1'($urandom_range(0, 1));
            check("t3_valid", 128'(ct_valid), 128'd1);
            check("t3_data",  128'(ct_data), 128'(exp3[idx]));
            @(posedge clk);
            if (ct_ready) idx++;
            #1;
        end
        ct_ready = 1'b0;
        check("t3_word_count", 128'(idx), 128'd4);
        check("t3_done", 128'(block_done), 128'd1);
        check("t3_valid_off", 128'(ct_valid), 128'd0);
        tick();

        // Test 4: clear after two words restarts the block.
        send_word(32'hDEAD0000);
        send_word(32'hDEAD0001);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_busy_clr", 128'(busy), 128'd0);
        check("t4_ready_clr", 128'(pt_ready), 128'd1);
        check("t4_block_clr", core_block, 128'd0);
        blk = 128'h33333333_22222222_11111111_00000000;
        for (int i = 0; i < 4; i++) send_word(blk[i*32 +: 32]);
        check("t4_start", 128'(core_start), 128'd1);
        check("t4_block", core_block, blk);
        tick();                       // WAIT
        core_reply(~blk);
        drain_all("t4", ~blk);
        tick();

        // Test 5: core_done while collecting is ignored.
        core_reply({128{1'b1}});
        check("t5_novalid", 128'(ct_valid), 128'd0);
        check("t5_ready",   128'(pt_ready), 128'd1);
        check("t5_busy",    128'(busy),     128'd0);
        tick();
        check("t5_novalid2", 128'(ct_valid), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_aes_block_assembler

`default_nettype wire
